dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT, default 1, sets the number of wait-state cycles inserted before each access (legal range 0..15).
REQ-002 Parameter DEPTH, default 64, sets the number of 32-bit words in the internal RAM (power of two).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  request valid; sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load; latched with req.
REQ-007 byte  input  1  1 = byte access (LDRB/STRB), 0 = word access; latched with req.
REQ-008 a  input  32  byte address; latched with req.
REQ-009 wd  input  32  store data; latched with req, and only wd[7:0] is used for byte stores.
REQ-010 rd  output  32  load data; valid only while ready=1.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high from the cycle after acceptance through the ready cycle.
REQ-013 err  output  1  out-of-range flag; valid only while ready=1.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RMW, DONE.
REQ-015 In IDLE with req=1, the block SHALL latch a, wd, we and byte, load the wait counter with WAIT, and go to WAIT, or to the access step directly if WAIT=0.
REQ-016 req SHALL be ignored in every state other than IDLE, and no queuing is provided.
REQ-017 WAIT SHALL decrement the counter each cycle and perform the access when the counter reaches 0.
REQ-018 Word index SHALL be a[log2(DEPTH)+1:2], and a[1:0] SHALL be ignored for word accesses.
REQ-019 A word load SHALL drive rd = RAM[index] in DONE.
REQ-020 A word store SHALL write RAM[index] <= wd at the access edge.
REQ-021 A byte load SHALL drive rd = {24'b0, lane}, where lane a[1:0] = 00/01/10/11 selects bits [7:0]/[15:8]/[23:16]/[31:24].
REQ-022 A byte store SHALL enter RMW for one cycle: read RAM[index], replace only the addressed lane with wd[7:0], and write back at the end of RMW; the other three lanes SHALL be unchanged.
REQ-023 Latency SHALL be measured from the accept edge k:
- ready=1 in cycle k+WAIT+1 for word loads, word stores and byte loads;
- ready=1 in cycle k+WAIT+2 for byte stores.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE, so consecutive accepts are at least one IDLE cycle apart.
REQ-025 A request is out of range if any bit of a above log2(DEPTH)+1 is 1; such a request SHALL NOT modify RAM, SHALL return rd=0, and SHALL assert err=1 with ready at the normal latency.
REQ-026 When ready=0, rd SHALL be 0 and err SHALL be 0.
REQ-027 busy SHALL be 0 in IDLE and 1 in WAIT, RMW and DONE.

Reset
REQ-028 While reset=1, the FSM SHALL be IDLE, the counter 0, and ready, busy, err and rd all 0.
REQ-029 A reset asserted mid-operation SHALL abort the access without issuing ready.
- A word store whose write edge has not occurred SHALL NOT modify RAM.
- A byte store aborted in RMW SHALL leave the target word unchanged.
REQ-030 RAM contents SHALL NOT be cleared by reset.
REQ-031 The first request SHALL be accepted on the first rising edge after reset deasserts, provided req=1.

Verification
REQ-032 WAIT=1: store word a=0x64, wd=0x00000007, then load word a=0x64 -> ready in cycle k+2 for each request; load returns rd=0x00000007, err=0.
REQ-033 Word 0x10 holds 0xAABBCCDD; STRB a=0x12, wd=0x55 -> ready at k+3; then word load a=0x10 returns 0xAA55CCDD.
REQ-034 Word 0x20 holds 0x11223344; LDRB at a=0x20/0x21/0x22/0x23 -> rd = 0x44/0x33/0x22/0x11, each zero-extended.
REQ-035 Store to a=0x100 (DEPTH=64) -> ready with err=1, rd=0; a word load at 0x00 afterwards returns its prior value.
REQ-036 Word store issued, reset pulsed in WAIT -> no ready pulse, target word unchanged, busy=0; a new request after reset completes normally.
REQ-037 WAIT=0 with req held high continuously -> accepts occur every 2nd cycle; ready is high in every 2nd cycle and never on consecutive cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word/byte data memory with read-modify-write byte stores
module dmem_responder #(
  parameter int WAIT  = 1,
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_op,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        busy,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_N = 4'(WAIT);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RMW  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  logic [1:0]    state, state_n;
  logic [3:0]    cnt;
  logic [31:0]   a_q, wd_q, a_c, wd_c, cur, merged;
  logic          we_q, byte_q, we_c, byte_c, oor_c, go, acc_n;
  logic [AW-1:0] idx_c;
  logic [4:0]    sh;
  logic [7:0]    lane;
  logic [31:0]   ram [DEPTH];
  // In IDLE the live inputs describe the access (WAIT=0 acts on them at once); afterwards the latched copy does
  always_comb begin
    a_c     = state == S_IDLE ? a : a_q;
    wd_c    = state == S_IDLE ? wd : wd_q;
    we_c    = state == S_IDLE ? we : we_q;
    byte_c  = state == S_IDLE ? byte_op : byte_q;
    oor_c   = |(a_c >> (AW + 2));
    idx_c   = a_c[AW+1:2];
    sh      = {a_c[1:0], 3'b000};
    cur     = ram[idx_c];
    lane    = 8'(cur >> sh);
    merged  = (cur & ~(32'h0000_00ff << sh)) | (32'(wd_c[7:0]) << sh);
    go      = (state == S_IDLE && req && WAIT_N == 4'd0) || (state == S_WAIT && cnt <= 4'd1);
    acc_n   = we_c && byte_c;
    state_n = state == S_IDLE ? (req ? (WAIT_N == 4'd0 ? (acc_n ? S_RMW : S_DONE) : S_WAIT) : S_IDLE) :
              state == S_WAIT ? (cnt <= 4'd1 ? (acc_n ? S_RMW : S_DONE) : S_WAIT) :
              state == S_RMW  ? S_DONE : S_IDLE;
    ready   = state == S_DONE;
    busy    = state != S_IDLE;
    err     = ready && oor_c;
    rd      = ready && !we_c && !oor_c ? (byte_c ? {24'b0, lane} : cur) : 32'b0;
  end
  // FSM, wait counter and request latch; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      a_q    <= 32'b0;
      wd_q   <= 32'b0;
      we_q   <= 1'b0;
      byte_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && req) begin
        a_q    <= a;
        wd_q   <= wd;
        we_q   <= we;
        byte_q <= byte_op;
        cnt    <= WAIT_N;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  // RAM is never cleared; word stores land at the access edge, byte stores at the end of RMW
  always_ff @(posedge clk) begin
    if (go && we_c && !byte_c && !oor_c)
      ram[idx_c] <= wd_c;
    else if (state == S_RMW && !oor_c)
      ram[idx_c] <= merged;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table plus reset-abort and back-to-back sequences
module tb_dmem_responder;
  logic        clk = 0, reset = 1;
  logic        req = 0, we = 0, byte_op = 0;
  logic [31:0] a = 0, wd = 0, rd;
  logic        ready, busy, err;
  logic        req0 = 0, we0 = 0, byte0 = 0;
  logic [31:0] a0 = 0, wd0 = 0, rd0;
  logic        ready0, busy0, err0;
  int checks = 0, errors = 0;

  dmem_responder #(.WAIT(1), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .byte_op(byte_op), .a(a), .wd(wd),
    .rd(rd), .ready(ready), .busy(busy), .err(err));
  dmem_responder #(.WAIT(0), .DEPTH(64)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .byte_op(byte0), .a(a0), .wd(wd0),
    .rd(rd0), .ready(ready0), .busy(busy0), .err(err0));

  always #5 clk = ~clk;

  typedef struct {
    logic        w, b;
    logic [31:0] addr, data;
    int          lat;
    logic [31:0] rd;
    logic        err;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(logic w, logic b, logic [31:0] addr, logic [31:0] data, int lat, logic [31:0] r, logic e);
    vec_t v;
    v.w = w; v.b = b; v.addr = addr; v.data = data; v.lat = lat; v.rd = r; v.err = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic b, input logic [31:0] addr, input logic [31:0] data);
    wait_idle();
    req = 1; we = w; byte_op = b; a = addr; wd = data;
    @(posedge clk); #1;
    req = 0;
  endtask

  task automatic do_op(input logic w, input logic b, input logic [31:0] addr, input logic [31:0] data,
                       output int lat, output logic [31:0] r, output logic e);
    lat = -1; r = 32'hx; e = 1'bx;
    issue(w, b, addr, data);
    for (int n = 0; n < 20; n++) begin
      if (ready) begin
        lat = n; r = rd; e = err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("ready_one_cycle", {31'b0, ready}, 32'd0);
    chk("rd_idle_zero", rd, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] r;
    logic e;
    bit seen;
    vq.push_back(mk(1, 0, 32'h64, 32'h7, 1, 0, 0));
    vq.push_back(mk(0, 0, 32'h64, 0, 1, 32'h7, 0));
    vq.push_back(mk(0, 0, 32'h40, 0, 1, 32'h12345678, 0));
    vq.push_back(mk(1, 0, 32'h10, 32'hAABBCCDD, 1, 0, 0));
    vq.push_back(mk(1, 1, 32'h12, 32'h55, 2, 0, 0));
    vq.push_back(mk(0, 0, 32'h10, 0, 1, 32'hAA55CCDD, 0));
    vq.push_back(mk(0, 0, 32'h13, 0, 1, 32'hAA55CCDD, 0));
    vq.push_back(mk(1, 1, 32'h10, 32'hFFFFFF77, 2, 0, 0));
    vq.push_back(mk(0, 0, 32'h10, 0, 1, 32'hAA55CC77, 0));
    vq.push_back(mk(1, 0, 32'h20, 32'h11223344, 1, 0, 0));
    vq.push_back(mk(0, 1, 32'h20, 0, 1, 32'h44, 0));
    vq.push_back(mk(0, 1, 32'h21, 0, 1, 32'h33, 0));
    vq.push_back(mk(0, 1, 32'h22, 0, 1, 32'h22, 0));
    vq.push_back(mk(0, 1, 32'h23, 0, 1, 32'h11, 0));
    vq.push_back(mk(1, 0, 32'h0, 32'hCAFEF00D, 1, 0, 0));
    vq.push_back(mk(1, 0, 32'h100, 32'hDEADBEEF, 1, 0, 1));
    vq.push_back(mk(0, 0, 32'h0, 0, 1, 32'hCAFEF00D, 0));
    vq.push_back(mk(0, 0, 32'h100, 0, 1, 0, 1));
    vq.push_back(mk(1, 1, 32'h103, 32'h99, 2, 0, 1));
    vq.push_back(mk(0, 0, 32'h0, 0, 1, 32'hCAFEF00D, 0));
    vq.push_back(mk(1, 0, 32'hFC, 32'h01020304, 1, 0, 0));
    vq.push_back(mk(1, 1, 32'hFF, 32'h9A, 2, 0, 0));
    vq.push_back(mk(0, 0, 32'hFC, 0, 1, 32'h9A020304, 0));
    vq.push_back(mk(1, 0, 32'h30, 32'h11111111, 1, 0, 0));
    vq.push_back(mk(1, 0, 32'h34, 32'hA1B2C3D4, 1, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, ready}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_err", {31'b0, err}, 0);
    chk("reset_rd", rd, 0);
    chk("reset_busy0", {31'b0, busy0}, 0);

    // request presented together with reset release is taken on the very next edge
    @(negedge clk);
    reset = 0; req = 1; we = 1; byte_op = 0; a = 32'h40; wd = 32'h12345678;
    @(posedge clk); #1;
    req = 0;
    chk("first_accept_busy", {31'b0, busy}, 1);
    chk("first_accept_ready_early", {31'b0, ready}, 0);
    @(posedge clk); #1;
    chk("first_accept_ready", {31'b0, ready}, 1);
    chk("first_accept_err", {31'b0, err}, 0);

    foreach (vq[i]) begin
      do_op(vq[i].w, vq[i].b, vq[i].addr, vq[i].data, lat, r, e);
      chk($sformatf("v%0d_lat", i), lat, vq[i].lat);
      chk($sformatf("v%0d_rd", i), r, vq[i].rd);
      chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vq[i].err});
    end

    // reset in WAIT aborts a word store
    issue(1, 0, 32'h30, 32'h22222222);
    chk("abort_w_busy_pre", {31'b0, busy}, 1);
    #2 reset = 1;
    #1;
    chk("abort_w_busy", {31'b0, busy}, 0);
    chk("abort_w_ready", {31'b0, ready}, 0);
    @(negedge clk);
    reset = 0;
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (ready) seen = 1;
    end
    chk("abort_w_no_ready", {31'b0, seen}, 0);
    do_op(0, 0, 32'h30, 0, lat, r, e);
    chk("abort_w_mem", r, 32'h11111111);
    chk("abort_w_lat", lat, 1);

    // reset in RMW leaves the target word untouched
    issue(1, 1, 32'h35, 32'hEE);
    @(posedge clk); #1;
    chk("abort_b_in_rmw", {30'b0, busy, ready}, 32'd2);
    #2 reset = 1;
    #1;
    chk("abort_b_busy", {31'b0, busy}, 0);
    @(negedge clk);
    reset = 0;
    do_op(0, 0, 32'h34, 0, lat, r, e);
    chk("abort_b_mem", r, 32'hA1B2C3D4);
    chk("abort_b_err", {31'b0, e}, 0);

    // WAIT=0 with req held high: accept every second cycle
    @(negedge clk);
    req0 = 1; we0 = 1; byte0 = 0; a0 = 32'h8; wd0 = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("w0_ready_%0d", i), {31'b0, ready0}, {31'b0, i % 2 == 0});
      chk($sformatf("w0_busy_%0d", i), {31'b0, busy0}, {31'b0, i % 2 == 0});
    end
    @(negedge clk);
    we0 = 0;
    @(posedge clk); #1;
    req0 = 0;
    chk("w0_load_ready", {31'b0, ready0}, 1);
    chk("w0_load_rd", rd0, 32'h0BADF00D);
    chk("w0_load_err", {31'b0, err0}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hung expected finish");
    $fatal(1, "timeout");
  end
endmodule
